// File: rtl/pe_seq_pkg.sv
// Shared state encoding, phase selects and counter width for the PE group sequencer.
// Phase-select values are also consumed by the software driver header generator.
package pe_seq_pkg;

    localparam int CntWidthDefault = 16;

    typedef logic [2:0] seqState_t;

    localparam seqState_t StIdle  = 3'd0;
    localparam seqState_t StClear = 3'd1;
    localparam seqState_t StLoadW = 3'd2;
    localparam seqState_t StLoadI = 3'd3;
    localparam seqState_t StLoadO = 3'd4;
    localparam seqState_t StDrain = 3'd5;
    localparam seqState_t StDone  = 3'd6;

    typedef logic [1:0] phaseSel_t;

    localparam phaseSel_t PhaseW     = 2'd0;
    localparam phaseSel_t PhaseI     = 2'd1;
    localparam phaseSel_t PhaseO     = 2'd2;
    localparam phaseSel_t PhaseDrain = 2'd3;

    // Next phase after cur finishes, skipping any phase whose count is zero.
    // A zero psum count removes both the psum load and the drain.
    function automatic seqState_t nextActiveState(input seqState_t cur, input logic wNz,
                                                  input logic iNz, input logic oNz);
        seqState_t nxt;
        nxt = StDone;
        case (cur)
            StClear: begin
                if (wNz)      nxt = StLoadW;
                else if (iNz) nxt = StLoadI;
                else if (oNz) nxt = StLoadO;
            end
            StLoadW: begin
                if (iNz)      nxt = StLoadI;
                else if (oNz) nxt = StLoadO;
            end
            StLoadI: begin
                if (oNz) nxt = StLoadO;
            end
            StLoadO: nxt = StDrain;
            default: nxt = StDone;
        endcase
        return nxt;
    endfunction

    function automatic phaseSel_t phaseOf(input seqState_t st);
        phaseSel_t ph;
        case (st)
            StLoadI: ph = PhaseI;
            StLoadO: ph = PhaseO;
            StDrain: ph = PhaseDrain;
            default: ph = PhaseW;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/pe_seq_phase_cnt.sv
// Per-phase word counter: clears on command, counts beats and flags the last beat.
// Wraps to zero on the last beat so the next phase starts from zero.
module pe_seq_phase_cnt
    import pe_seq_pkg::*;
#(
    parameter int CntWidth = CntWidthDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    input  logic [CntWidth-1:0] target,
    output logic                last
);

    logic [CntWidth-1:0] count;

    // Full-width compare; a zero target never matches, but zero phases are never entered.
    assign last = (count == (target - CntWidth'(1)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : (count + CntWidth'(1));
        end
    end

endmodule

// File: rtl/pe_group_sequencer.sv
// Command-driven sequencer for one PE group pass: clear, load W/I/O, drain results.
// Optional perf counters (perf_cycles, perf_stall) when PE_SEQ_PERF_CNT_EN is defined.
module pe_group_sequencer
    import pe_seq_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int CntWidth  = CntWidthDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CntWidth-1:0]  cmd_w_cnt,
    input  logic [CntWidth-1:0]  cmd_i_cnt,
    input  logic [CntWidth-1:0]  cmd_o_cnt,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [DataWidth-1:0] src_data,
    output logic                 pe_aclr,
    output logic [DataWidth-1:0] pe_data,
    output logic                 pe_w_valid,
    input  logic                 pe_w_rdy,
    output logic                 pe_i_valid,
    input  logic                 pe_i_rdy,
    output logic                 pe_o_valid,
    input  logic                 pe_o_rdy,
    input  logic                 pe_out_valid,
    output logic                 pe_out_rdy,
    input  logic [DataWidth-1:0] pe_out_data,
    output logic                 dst_valid,
    input  logic                 dst_ready,
    output logic [DataWidth-1:0] dst_data,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           dbgState
`ifdef PE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stall
`endif
);

    // Handshakes: a beat moves on a rising edge only when valid, ready and clk_en are all high.
    // Valid never waits on ready; the steering here is purely combinational.

    seqState_t           state;
    seqState_t           nextState;
    logic [CntWidth-1:0] cntW;
    logic [CntWidth-1:0] cntI;
    logic [CntWidth-1:0] cntO;
    logic [CntWidth-1:0] target;
    logic                lastBeat;
    logic                inLoadW;
    logic                inLoadI;
    logic                inLoadO;
    logic                inDrain;
    logic                loadRdy;
    logic                srcXfer;
    logic                drainXfer;
    logic                beat;
    logic                cmdAccept;
    logic                wNz;
    logic                iNz;
    logic                oNz;

    assign inLoadW = (state == StLoadW);
    assign inLoadI = (state == StLoadI);
    assign inLoadO = (state == StLoadO);
    assign inDrain = (state == StDrain);

    assign wNz = (cntW != '0);
    assign iNz = (cntI != '0);
    assign oNz = (cntO != '0);

    assign cmdAccept = (state == StIdle) && cmd_valid && clk_en;
    assign loadRdy   = (inLoadW && pe_w_rdy) || (inLoadI && pe_i_rdy) || (inLoadO && pe_o_rdy);
    assign srcXfer   = clk_en && src_valid && loadRdy;
    assign drainXfer = clk_en && inDrain && pe_out_valid && dst_ready;
    assign beat      = srcXfer || drainXfer;

    always_comb begin
        target = '0;
        case (phaseOf(state))
            PhaseW:     target = cntW;
            PhaseI:     target = cntI;
            PhaseO:     target = cntO;
            PhaseDrain: target = cntO;
            default:    target = '0;
        endcase
    end

    pe_seq_phase_cnt #(
        .CntWidth(CntWidth)
    ) u_phaseCnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cmdAccept),
        .inc   (beat),
        .target(target),
        .last  (lastBeat)
    );

    always_comb begin
        nextState = state;
        case (state)
            StIdle:  if (cmd_valid) nextState = StClear;
            StClear: nextState = nextActiveState(StClear, wNz, iNz, oNz);
            StLoadW, StLoadI, StLoadO: begin
                if (beat && lastBeat) nextState = nextActiveState(state, wNz, iNz, oNz);
            end
            StDrain: if (beat && lastBeat) nextState = StDone;
            StDone:  nextState = StIdle;
            default: nextState = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= StIdle;
        end else if (clk_en) begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cntW <= '0;
            cntI <= '0;
            cntO <= '0;
        end else if (cmdAccept) begin
            cntW <= cmd_w_cnt;
            cntI <= cmd_i_cnt;
            cntO <= cmd_o_cnt;
        end
    end

    assign cmd_ready  = (state == StIdle) && clk_en;
    assign busy       = (state != StIdle);
    // done follows state, so a pass ending while clk_en is low keeps it high until resumed.
    assign done       = (state == StDone);
    assign pe_aclr    = (state == StClear) && clk_en;
    assign pe_data    = src_data;
    assign pe_w_valid = inLoadW && src_valid && clk_en;
    assign pe_i_valid = inLoadI && src_valid && clk_en;
    assign pe_o_valid = inLoadO && src_valid && clk_en;
    assign src_ready  = loadRdy && clk_en;
    assign dst_valid  = inDrain && pe_out_valid && clk_en;
    assign pe_out_rdy = inDrain && dst_ready && clk_en;
    assign dst_data   = pe_out_data;
    assign dbgState   = state;

`ifdef PE_SEQ_PERF_CNT_EN
    logic stallNow;

    assign stallNow = clk_en && (((inLoadW || inLoadI || inLoadO) && src_valid && !loadRdy)
                                 || (inDrain && pe_out_valid && !dst_ready));

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (cmdAccept) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && clk_en && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
            if (stallNow && (perf_stall != '1))        perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
